// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the program ROM over MAB/MDB, sizes each opcode,
// gathers its extension words and presents the bundle to the decoder via valid/ready.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'hC000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MDB_in,
    output logic [15:0] MAB_out,
    output logic [15:0] INSTR_out,
    output logic [15:0] EXT1_out,
    output logic [15:0] EXT2_out,
    output logic [1:0]  EXT_cnt,
    output logic [15:0] PC_out,
    output logic        ILLEGAL,
    output logic        INSTR_valid,
    input  logic        INSTR_ready,
    input  logic        BR_en,
    input  logic [15:0] BR_addr
);

    localparam int unsigned W          = 16;
    localparam logic [W-1:0] RESET_ADDR = RESET_PC & 16'hFFFE;
    localparam logic [W-1:0] WORD_STEP  = W'(2);
    localparam logic [W-1:0] OP_RETI    = 16'h1300;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_EXT1 = 2'd1,
        S_EXT2 = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] fetch_pc_q, fetch_pc_d;
    logic [W-1:0] instr_d, pc_d, ext1_d, ext2_d;
    logic [1:0]   cnt_d;
    logic         ill_d, valid_d;

    logic [1:0]   op_cnt_c;
    logic         op_ill_c;
    logic         fmt1_c, fmt2_c, src_ext_c, dst_ext_c;
    logic [1:0]   as_c;
    logic [3:0]   rs_c;

    assign MAB_out = fetch_pc_q;

    // Opcode length decode on the word currently on the bus
    always_comb begin
        op_ill_c  = (MDB_in[15:12] == 4'h0) ||
                    ((MDB_in[15:12] == 4'h1) && (MDB_in[11:7] > 5'b00110));
        fmt1_c    = (MDB_in[15:14] != 2'b00);
        fmt2_c    = (MDB_in[15:12] == 4'h1) && !op_ill_c && (MDB_in != OP_RETI);
        as_c      = MDB_in[5:4];
        rs_c      = fmt1_c ? MDB_in[11:8] : MDB_in[3:0];
        src_ext_c = (fmt1_c || fmt2_c) &&
                    (((as_c == 2'b01) && (rs_c != 4'd3)) ||
                     ((as_c == 2'b11) && (rs_c == 4'd0)));
        dst_ext_c = fmt1_c && MDB_in[7];
        op_cnt_c  = {1'b0, src_ext_c} + {1'b0, dst_ext_c};
    end

    // Next-state and bundle capture
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = INSTR_out;
        pc_d       = PC_out;
        ext1_d     = EXT1_out;
        ext2_d     = EXT2_out;
        cnt_d      = EXT_cnt;
        ill_d      = ILLEGAL;

        case (state_q)
            S_OP: begin
                instr_d    = MDB_in;
                pc_d       = fetch_pc_q;
                cnt_d      = op_cnt_c;
                ill_d      = op_ill_c;
                fetch_pc_d = fetch_pc_q + WORD_STEP;
                state_d    = (op_cnt_c == 2'd0) ? S_HOLD : S_EXT1;
            end
            S_EXT1: begin
                ext1_d     = MDB_in;
                fetch_pc_d = fetch_pc_q + WORD_STEP;
                state_d    = (EXT_cnt == 2'd2) ? S_EXT2 : S_HOLD;
            end
            S_EXT2: begin
                ext2_d     = MDB_in;
                fetch_pc_d = fetch_pc_q + WORD_STEP;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (INSTR_ready) state_d = S_OP;
            end
            default: state_d = S_OP;
        endcase

        // A redirect drops any partial bundle; an accepted bundle stays accepted
        if (BR_en) begin
            state_d    = S_OP;
            fetch_pc_d = BR_addr & 16'hFFFE;
        end

        valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OP;
            fetch_pc_q  <= RESET_ADDR;
            INSTR_out   <= '0;
            PC_out      <= RESET_ADDR;
            EXT1_out    <= '0;
            EXT2_out    <= '0;
            EXT_cnt     <= '0;
            ILLEGAL     <= 1'b0;
            INSTR_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            INSTR_out   <= instr_d;
            PC_out      <= pc_d;
            EXT1_out    <= ext1_d;
            EXT2_out    <= ext2_d;
            EXT_cnt     <= cnt_d;
            ILLEGAL     <= ill_d;
            INSTR_valid <= valid_d;
        end
    end

endmodule
